// File: rtl/gate_chk_pkg.sv
// Shared encodings for the gate response checker: golden op codes, FSM state
// codes and the golden gate function used by the reference model.
package gate_chk_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int MAX_IN = 8;

    // Only the low num_in bits take part, so AND is not spoiled by the zero padding.
    function automatic logic gate_expected(input logic [1:0] op,
                                           input logic [MAX_IN-1:0] vec,
                                           input int num_in);
        logic and_r;
        logic or_r;
        logic xor_r;
        logic result;
        and_r = 1'b1;
        or_r  = 1'b0;
        xor_r = 1'b0;
        for (int i = 0; i < MAX_IN; i++) begin
            if (i < num_in) begin
                and_r = and_r & vec[i];
                or_r  = or_r | vec[i];
                xor_r = xor_r ^ vec[i];
            end
        end
        case (op)
            OP_AND:  result = and_r;
            OP_OR:   result = or_r;
            OP_XOR:  result = xor_r;
            default: result = ~or_r;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden output for a NUM_IN-input gate selected by op; kept
// separate so other checkers can reuse it.
module gate_ref_model
    import gate_chk_pkg::*;
#(
    parameter int NUM_IN = 2
) (
    input  logic [1:0]        op,
    input  logic [NUM_IN-1:0] vec,
    output logic              expected
);

    logic [MAX_IN-1:0] vec_ext;

    assign vec_ext  = MAX_IN'(vec);
    assign expected = gate_expected(op, vec_ext, NUM_IN);

endmodule

// File: rtl/gate_response_checker.sv
// Exhaustive stimulus generator and response checker for a combinational gate.
// Define GATE_CHK_FAIL_CAPTURE_EN to capture the first failing vector of a sweep.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int NUM_IN        = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    output logic [NUM_IN-1:0] stim,
    input  logic              resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [NUM_IN-1:0] first_fail_vec,
    output logic              first_fail_valid
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] settle_cnt;
    logic             expected;
    logic             mismatch;

    gate_ref_model #(.NUM_IN(NUM_IN)) u_ref (
        .op       (op_q),
        .vec      (stim),
        .expected (expected)
    );

    assign mismatch = (state == ST_SAMPLE) && (resp != expected);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= OP_AND;
            settle_cnt <= '0;
            stim       <= '0;
            err_count  <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_SETTLE;
                        op_q       <= op;
                        settle_cnt <= '0;
                        stim       <= '0;
                        err_count  <= '0;
                        pass       <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == CNT_LAST) begin
                        settle_cnt <= '0;
                        state      <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    // Saturate rather than wrap so a long failing sweep never reads as clean.
                    if (mismatch && (err_count != '1)) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (stim == '1) begin
                        state <= ST_DONE;
                    end else begin
                        stim  <= stim + 1'b1;
                        state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    pass  <= (err_count == '0);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef GATE_CHK_FAIL_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            first_fail_valid <= 1'b0;
        end else if (mismatch && !first_fail_valid) begin
            first_fail_vec   <= stim;
            first_fail_valid <= 1'b1;
        end
    end
`else
    assign first_fail_vec   = '0;
    assign first_fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized self-checking bench for gate_response_checker against a
// popcount-based model of the gate functions and sweep outcome.
module tb_gate_response_checker;

    localparam int N  = 2;
    localparam int S  = 2;
    localparam int N2 = 3;
    localparam int S2 = 1;

`ifdef GATE_CHK_FAIL_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] stim;
    logic         resp;
    logic         busy, done, pass;
    logic [7:0]   err_count;
    logic [N-1:0] ffv;
    logic         ffval;

    logic          start2 = 1'b0;
    logic [1:0]    op2 = 2'b00;
    logic [N2-1:0] stim2;
    logic          resp2;
    logic          busy2, done2, pass2;
    logic [0:0]    err2;
    logic [N2-1:0] ffv2;
    logic          ffval2;

    int n_vec = 0;
    int n_miss = 0;

    int           resp_mode = 0;
    logic [1:0]   gate_op = 2'b00;
    logic [3:0]   err_mask = 4'b0000;
    logic         glitch = 1'b0;
    bit           glitch_en = 1'b0;

    int           done_cycle;
    int           done_count;
    logic [N-1:0] trace[$];

    gate_response_checker #(.NUM_IN(N), .SETTLE_CYCLES(S), .ERR_W(8)) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .op (op), .stim (stim),
        .resp (resp), .busy (busy), .done (done), .pass (pass),
        .err_count (err_count), .first_fail_vec (ffv), .first_fail_valid (ffval)
    );

    gate_response_checker #(.NUM_IN(N2), .SETTLE_CYCLES(S2), .ERR_W(1)) dut_sat (
        .clk (clk), .rst_n (rst_n), .start (start2), .op (op2), .stim (stim2),
        .resp (resp2), .busy (busy2), .done (done2), .pass (pass2),
        .err_count (err2), .first_fail_vec (ffv2), .first_fail_valid (ffval2)
    );

    always #5 clk = ~clk;

    // Gate functions defined by how many inputs are high.
    function automatic logic golden(input logic [1:0] f, input int v, input int n);
        int ones;
        ones = $countones(v);
        case (f)
            2'b00:   return ones == n;
            2'b01:   return ones > 0;
            2'b10:   return (ones % 2) == 1;
            default: return ones == 0;
        endcase
    endfunction

    always_comb begin
        resp = 1'b0;
        if (resp_mode != 1) resp = golden(gate_op, int'(stim), N) ^ err_mask[stim] ^ glitch;
    end

    assign resp2 = ~golden(op2, int'(stim2), N2);

    task automatic model_sweep(input logic [1:0] f, output int errs, output int first);
        errs = 0;
        first = -1;
        for (int v = 0; v < (1 << N); v++) begin
            logic r;
            r = (resp_mode == 1) ? 1'b0 : (golden(gate_op, v, N) ^ err_mask[v]);
            if (r != golden(f, v, N)) begin
                errs++;
                if (first < 0) first = v;
            end
        end
    endtask

    task automatic run_sweep(input logic [1:0] sweep_op, input int budget);
        done_cycle = -1;
        done_count = 0;
        trace.delete();
        @(negedge clk);
        start = 1'b1;
        op = sweep_op;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom_range(0, 3));
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (glitch_en && ((cyc % (S + 1)) != S) && (cyc < (1 << N) * (S + 1)))
                glitch = 1'($urandom_range(0, 1));
            else
                glitch = 1'b0;
            if (((cyc % (S + 1)) == S) && (cyc < (1 << N) * (S + 1))) trace.push_back(stim);
            if (done) begin
                if (done_cycle < 0) done_cycle = cyc;
                done_count++;
            end
            @(negedge clk);
        end
        glitch = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({stim, busy, done, pass, err_count, ffv, ffval} !== '0) begin
            n_miss++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {stim, busy, done, pass, err_count, ffv, ffval});
        end
        n_vec++;
        if ({stim2, busy2, done2, pass2, err2, ffv2, ffval2} !== '0) begin
            n_miss++;
            $display("[TB] FAIL reset_outputs_sat: got %h required 0",
                     {stim2, busy2, done2, pass2, err2, ffv2, ffval2});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL idle_without_start: busy got %b required 0", busy);
        end
    endtask

    task automatic test_or_correct;
        int errs, first;
        resp_mode = 0; gate_op = 2'b01; err_mask = 4'b0000; glitch_en = 1'b0;
        model_sweep(2'b01, errs, first);
        run_sweep(2'b01, 16);
        n_vec++;
        if (trace.size() !== (1 << N)) begin
            n_miss++;
            $display("[TB] FAIL or_trace_len: got %0d required %0d", trace.size(), 1 << N);
        end
        for (int k = 0; k < trace.size(); k++) begin
            n_vec++;
            if (trace[k] !== N'(k)) begin
                n_miss++;
                $display("[TB] FAIL or_stim_seq[%0d]: got %0d required %0d", k, trace[k], k);
            end
        end
        n_vec++;
        if (done_cycle !== (1 << N) * (S + 1) || done_count !== 1) begin
            n_miss++;
            $display("[TB] FAIL or_done_timing: got cycle %0d count %0d required cycle %0d count 1",
                     done_cycle, done_count, (1 << N) * (S + 1));
        end
        n_vec++;
        if (err_count !== 8'(errs) || pass !== (errs == 0)) begin
            n_miss++;
            $display("[TB] FAIL or_result: got err %0d pass %b required err %0d pass %b",
                     err_count, pass, errs, errs == 0);
        end
        n_vec++;
        if (busy !== 1'b0 || stim !== '1) begin
            n_miss++;
            $display("[TB] FAIL or_hold: got busy %b stim %0d required busy 0 stim %0d",
                     busy, stim, (1 << N) - 1);
        end
    endtask

    task automatic test_tied_zero;
        int errs, first;
        resp_mode = 1; glitch_en = 1'b0;
        model_sweep(2'b01, errs, first);
        run_sweep(2'b01, 16);
        resp_mode = 0;
        n_vec++;
        if (err_count !== 8'(errs) || pass !== (errs == 0)) begin
            n_miss++;
            $display("[TB] FAIL tied0_result: got err %0d pass %b required err %0d pass %b",
                     err_count, pass, errs, errs == 0);
        end
        n_vec++;
        if (ffval !== (CAP && errs > 0) || ffv !== (CAP ? N'(first) : '0)) begin
            n_miss++;
            $display("[TB] FAIL tied0_first_fail: got valid %b vec %0d required valid %b vec %0d",
                     ffval, ffv, CAP && errs > 0, CAP ? first : 0);
        end
    endtask

    task automatic test_and_vs_or;
        int errs, first;
        resp_mode = 0; gate_op = 2'b01; err_mask = 4'b0000; glitch_en = 1'b0;
        model_sweep(2'b00, errs, first);
        run_sweep(2'b00, 16);
        n_vec++;
        if (err_count !== 8'(errs) || pass !== (errs == 0)) begin
            n_miss++;
            $display("[TB] FAIL and_vs_or_result: got err %0d pass %b required err %0d pass %b",
                     err_count, pass, errs, errs == 0);
        end
        n_vec++;
        if (ffval !== (CAP && errs > 0) || ffv !== (CAP ? N'(first) : '0)) begin
            n_miss++;
            $display("[TB] FAIL and_vs_or_first_fail: got valid %b vec %0d required valid %b vec %0d",
                     ffval, ffv, CAP && errs > 0, CAP ? first : 0);
        end
    endtask

    task automatic test_random;
        int errs, first;
        logic [1:0] f;
        for (int it = 0; it < 8; it++) begin
            f = 2'($urandom_range(0, 3));
            gate_op = 2'($urandom_range(0, 3));
            err_mask = 4'($urandom_range(0, 15));
            resp_mode = 0; glitch_en = 1'b1;
            model_sweep(f, errs, first);
            run_sweep(f, 15);
            n_vec++;
            if (err_count !== 8'(errs) || pass !== (errs == 0) || done_cycle !== (1 << N) * (S + 1)) begin
                n_miss++;
                $display("[TB] FAIL random[%0d]: got err %0d pass %b done@%0d required err %0d pass %b done@%0d",
                         it, err_count, pass, done_cycle, errs, errs == 0, (1 << N) * (S + 1));
            end
            n_vec++;
            if (ffval !== (CAP && errs > 0) || (CAP && errs > 0 && ffv !== N'(first))) begin
                n_miss++;
                $display("[TB] FAIL random_first_fail[%0d]: got valid %b vec %0d required valid %b vec %0d",
                         it, ffval, ffv, CAP && errs > 0, first);
            end
        end
        glitch_en = 1'b0;
        err_mask = 4'b0000;
    endtask

    task automatic test_back_to_back;
        int errs, first, d0, d1, dcount;
        resp_mode = 0; gate_op = 2'b10; err_mask = 4'b0001; glitch_en = 1'b0;
        model_sweep(2'b10, errs, first);
        d0 = -1; d1 = -1; dcount = 0;
        @(negedge clk);
        start = 1'b1;
        op = 2'b10;
        @(posedge clk);
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                if (d0 < 0) d0 = cyc; else if (d1 < 0) d1 = cyc;
            end
            if (cyc == 6 || cyc == 20) op = ~op;
            if (cyc == 13) begin
                n_vec++;
                if (busy !== 1'b0 || err_count !== 8'(errs) || pass !== (errs == 0)) begin
                    n_miss++;
                    $display("[TB] FAIL b2b_gap: got busy %b err %0d pass %b required busy 0 err %0d pass %b",
                             busy, err_count, pass, errs, errs == 0);
                end
                op = 2'b10;
                err_mask = 4'b0000;
            end
            if (cyc == 14) begin
                n_vec++;
                if (busy !== 1'b1 || err_count !== 8'd0 || pass !== 1'b0) begin
                    n_miss++;
                    $display("[TB] FAIL b2b_restart: got busy %b err %0d pass %b required busy 1 err 0 pass 0",
                             busy, err_count, pass);
                end
            end
            if (cyc == 26) start = 1'b0;
        end
        n_vec++;
        if (dcount !== 2 || d0 !== 12 || d1 !== 26) begin
            n_miss++;
            $display("[TB] FAIL b2b_done: got count %0d at %0d,%0d required count 2 at 12,26", dcount, d0, d1);
        end
        n_vec++;
        if (err_count !== 8'd0 || pass !== 1'b1 || busy !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL b2b_second_result: got err %0d pass %b busy %b required err 0 pass 1 busy 0",
                     err_count, pass, busy);
        end
    endtask

    task automatic test_reset_abort;
        int dcount;
        resp_mode = 0; gate_op = 2'b01; err_mask = 4'b0001; glitch_en = 1'b0;
        dcount = 0;
        @(negedge clk);
        start = 1'b1;
        op = 2'b01;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++;
        if (err_count !== 8'd1 || stim !== N'(1) || busy !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL abort_pre: got err %0d stim %0d busy %b required err 1 stim 1 busy 1",
                     err_count, stim, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (stim !== '0 || busy !== 1'b0 || err_count !== 8'd0 || done !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL abort_immediate: got stim %0d busy %b err %0d done %b required all 0",
                     stim, busy, err_count, done);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (done) dcount++;
        end
        n_vec++;
        if (dcount !== 0 || busy !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL abort_no_done: got done count %0d busy %b required 0 and 0", dcount, busy);
        end
        err_mask = 4'b0000;
        run_sweep(2'b01, 16);
        n_vec++;
        if (err_count !== 8'd0 || pass !== 1'b1 || done_cycle !== 12) begin
            n_miss++;
            $display("[TB] FAIL abort_recover: got err %0d pass %b done@%0d required err 0 pass 1 done@12",
                     err_count, pass, done_cycle);
        end
    endtask

    task automatic test_saturation;
        int errs, d0, sat_exp;
        for (int it = 0; it < 2; it++) begin
            op2 = 2'($urandom_range(0, 3));
            errs = 0;
            for (int v = 0; v < (1 << N2); v++)
                if (~golden(op2, v, N2) != golden(op2, v, N2)) errs++;
            sat_exp = (errs > 1) ? 1 : errs;
            d0 = -1;
            @(negedge clk);
            start2 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start2 = 1'b0;
            for (int cyc = 0; cyc < 20; cyc++) begin
                if (done2 && d0 < 0) d0 = cyc;
                if (cyc == 9) begin
                    n_vec++;
                    if (err2 !== 1'b1) begin
                        n_miss++;
                        $display("[TB] FAIL sat_mid[%0d]: got err %0d required 1", it, err2);
                    end
                end
                @(negedge clk);
            end
            n_vec++;
            if (err2 !== 1'(sat_exp) || pass2 !== 1'b0 || d0 !== (1 << N2) * (S2 + 1)) begin
                n_miss++;
                $display("[TB] FAIL sat_final[%0d]: got err %0d pass %b done@%0d required err %0d pass 0 done@%0d",
                         it, err2, pass2, d0, sat_exp, (1 << N2) * (S2 + 1));
            end
            n_vec++;
            if (ffval2 !== CAP || ffv2 !== '0 || stim2 !== '1) begin
                n_miss++;
                $display("[TB] FAIL sat_capture[%0d]: got valid %b vec %0d stim %0d required valid %b vec 0 stim 7",
                         it, ffval2, ffv2, stim2, CAP);
            end
        end
    endtask

    initial begin
        $display("[TB] gate_response_checker bench, fail capture build = %0d", CAP);
        test_reset();
        test_or_correct();
        test_tied_zero();
        test_and_vs_or();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
